// File: rtl/snake_engine_pkg.sv
// Shared types and constants for the snake game core.
package snake_engine_pkg;

    localparam int unsigned COORD_W = 6;

    // Coordinate is {row[2:0], col[2:0]}; bitmap bit index equals the coordinate value.
    typedef logic [COORD_W-1:0] coord_t;

    // Opposite directions differ only in bit 0.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PLACE,
        ST_OVER
    } state_t;

    localparam coord_t START_HEAD  = 6'o33;
    localparam coord_t START_BODY1 = 6'o32;
    localparam coord_t START_BODY2 = 6'o31;
    localparam coord_t START_FOOD  = 6'o55;

    function automatic dir_t dir_reverse(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    // Start position of body segment idx; segments past the initial three are zero.
    function automatic coord_t start_seg(input int unsigned idx);
        case (idx)
            0:       return START_HEAD;
            1:       return START_BODY1;
            2:       return START_BODY2;
            default: return '0;
        endcase
    endfunction

    // One cell in direction d, wrapping modulo 8 on both axes.
    function automatic coord_t coord_step(input coord_t c, input dir_t d);
        logic [2:0] row;
        logic [2:0] col;
        row = c[5:3];
        col = c[2:0];
        case (d)
            DIR_UP:    row = row - 3'd1;
            DIR_DOWN:  row = row + 3'd1;
            DIR_LEFT:  col = col - 3'd1;
            default:   col = col + 3'd1;
        endcase
        return {row, col};
    endfunction

endpackage

// File: rtl/snake_engine_if.sv
// Frame pulse, buttons and display/score outputs of the snake game core.
interface snake_engine_if;
    logic        i_fFrame;
    logic [3:0]  i_Btn;
    logic [63:0] o_Data;
    logic [5:0]  o_Score;
    logic        o_fGameOver;

    modport master (
        output i_fFrame, i_Btn,
        input  o_Data, o_Score, o_fGameOver
    );

    modport slave (
        input  i_fFrame, i_Btn,
        output o_Data, o_Score, o_fGameOver
    );
endinterface

// File: rtl/snake_engine_lfsr.sv
// Free-running 6-bit Fibonacci LFSR (x^6+x^5+1) used for food placement.
module snake_lfsr
    import snake_engine_pkg::*;
(
    input  logic   i_Clk,
    input  logic   i_Rst,
    output coord_t o_Val
);

    // Shift every clock; maximal-length taps keep the register out of the all-zero state.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_Val <= 6'b000001;
        end else begin
            o_Val <= {o_Val[4:0], o_Val[5] ^ o_Val[4]};
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: body/food state, stepping, collision and 8x8 bitmap generation.
module snake_engine
    import snake_engine_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 50,
    parameter int unsigned MAX_LEN         = 16,
    parameter int unsigned INIT_LEN        = 3
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    snake_engine_if.slave bus
);

    localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int unsigned LEN_W = 6;

    state_t           state_q, state_d;
    dir_t             dir_q, pend_q, btn_dir;
    coord_t           seg_q [MAX_LEN];
    coord_t           food_q, head_next, lfsr_val;
    logic [LEN_W-1:0] len_q, len_m1;
    logic [5:0]       score_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      data_q, map_d;
    logic [63:0]      seg_map [MAX_LEN];
    logic [MAX_LEN-1:0] hit_head, hit_lfsr;
    logic             btn_any_q, btn_valid, press, eat, collide, food_blocked;
    logic             frame_tick, step, place, restart, game_over, dir_upd;

    snake_lfsr u_lfsr (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .o_Val (lfsr_val)
    );

    assign press     = (|bus.i_Btn) & ~btn_any_q;
    assign head_next = coord_step(seg_q[0], pend_q);
    assign eat       = (head_next == food_q);
    assign len_m1    = len_q - LEN_W'(1);

    // Priority-select the requested direction: up > down > left > right.
    always_comb begin
        btn_valid = |bus.i_Btn;
        btn_dir   = DIR_RIGHT;
        if (bus.i_Btn[3])      btn_dir = DIR_UP;
        else if (bus.i_Btn[2]) btn_dir = DIR_DOWN;
        else if (bus.i_Btn[1]) btn_dir = DIR_LEFT;
    end

    // The tail is excluded from the head-collision check unless eating, because it vacates.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg
        localparam logic [LEN_W-1:0] IDX = LEN_W'(gi);
        logic live;
        assign live         = (IDX < len_q);
        assign hit_head[gi] = live && (seg_q[gi] == head_next) && !((IDX == len_m1) && !eat);
        assign hit_lfsr[gi] = live && (seg_q[gi] == lfsr_val);
        assign seg_map[gi]  = live ? (64'd1 << seg_q[gi]) : '0;
    end

    assign collide      = |hit_head;
    assign food_blocked = |hit_lfsr;

    // Combine live segments and food into the next bitmap.
    always_comb begin
        map_d = 64'd1 << food_q;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            map_d = map_d | seg_map[i];
        end
    end

    // Game state register.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus the step/place/restart strobes that drive the datapath.
    always_comb begin
        state_d    = state_q;
        frame_tick = 1'b0;
        step       = 1'b0;
        place      = 1'b0;
        restart    = 1'b0;
        game_over  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press) state_d = ST_RUN;
            end
            ST_RUN: begin
                frame_tick = bus.i_fFrame;
                if (bus.i_fFrame && (cnt_q == CNT_W'(FRAMES_PER_STEP - 1))) begin
                    step = 1'b1;
                    if (collide)  state_d = ST_OVER;
                    else if (eat) state_d = ST_PLACE;
                end
            end
            ST_PLACE: begin
                if (!food_blocked) begin
                    place   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                game_over = 1'b1;
                if (press) begin
                    restart = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A request is compared with the last applied direction, not the pending one.
    assign dir_upd = btn_valid && (state_q != ST_OVER) && (btn_dir != dir_reverse(dir_q));

    // Body, food, direction, score, frame counter and bitmap registers.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) seg_q[i] <= start_seg(i);
            len_q     <= LEN_W'(INIT_LEN);
            dir_q     <= DIR_RIGHT;
            pend_q    <= DIR_RIGHT;
            food_q    <= START_FOOD;
            score_q   <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            btn_any_q <= 1'b0;
        end else begin
            btn_any_q <= |bus.i_Btn;
            if (state_q != ST_OVER) data_q <= map_d;
            if (restart) begin
                for (int unsigned i = 0; i < MAX_LEN; i++) seg_q[i] <= start_seg(i);
                len_q   <= LEN_W'(INIT_LEN);
                dir_q   <= DIR_RIGHT;
                pend_q  <= DIR_RIGHT;
                food_q  <= START_FOOD;
                score_q <= '0;
                cnt_q   <= '0;
            end else begin
                if (frame_tick) cnt_q <= step ? '0 : cnt_q + CNT_W'(1);
                if (step)       dir_q <= pend_q;
                if (dir_upd)    pend_q <= btn_dir;
                if (step && !collide) begin
                    for (int unsigned i = MAX_LEN - 1; i > 0; i--) seg_q[i] <= seg_q[i-1];
                    seg_q[0] <= head_next;
                    if (eat) begin
                        if (len_q < LEN_W'(MAX_LEN)) len_q <= len_q + LEN_W'(1);
                        if (score_q != 6'd63)        score_q <= score_q + 6'd1;
                    end
                end
                if (place) food_q <= lfsr_val;
            end
        end
    end

    assign bus.o_Data      = data_q;
    assign bus.o_Score     = score_q;
    assign bus.o_fGameOver = game_over;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed vector table, steering sequence, random play.
module tb_snake_engine;

    localparam int FPS  = 50;
    localparam int MAXL = 16;
    localparam logic [63:0] ALL       = '1;
    localparam logic [63:0] RESET_MAP = 64'h0000_2000_0E00_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    snake_engine_if bus();

    snake_engine #(
        .FRAMES_PER_STEP (FPS),
        .MAX_LEN         (MAXL),
        .INIT_LEN        (3)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int misc    = 0;

    // Reference game model: body kept as a queue (front = head), directions as button bits.
    typedef enum {M_IDLE, M_RUN, M_PLACE, M_OVER} mstate_e;
    mstate_e     m_state;
    logic [5:0]  m_body[$];
    logic [5:0]  m_food, m_lfsr, m_score;
    int          m_dir, m_pend, m_cnt;
    logic [63:0] m_data;
    logic        m_prev_any;

    function automatic logic [5:0] neighbour(logic [5:0] h, int d);
        int r, c;
        r = int'(h) / 8;
        c = int'(h) % 8;
        case (d)
            8: r = (r + 7) % 8;
            4: r = (r + 1) % 8;
            2: c = (c + 7) % 8;
            default: c = (c + 1) % 8;
        endcase
        return 6'(r * 8 + c);
    endfunction

    function automatic int opposite(int d);
        case (d)
            8: return 4;
            4: return 8;
            2: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int clockwise(int d);
        case (d)
            8: return 1;
            1: return 4;
            4: return 2;
            default: return 8;
        endcase
    endfunction

    function automatic int pick(logic [3:0] b);
        if (b[3]) return 8;
        if (b[2]) return 4;
        if (b[1]) return 2;
        if (b[0]) return 1;
        return 0;
    endfunction

    function automatic bit in_body(logic [5:0] v);
        foreach (m_body[i]) if (m_body[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] picture();
        logic [63:0] p;
        p = '0;
        foreach (m_body[i]) p[m_body[i]] = 1'b1;
        p[m_food] = 1'b1;
        return p;
    endfunction

    task automatic model_restart();
        m_body.delete();
        m_body.push_back(6'o33);
        m_body.push_back(6'o32);
        m_body.push_back(6'o31);
        m_dir   = 1;
        m_pend  = 1;
        m_food  = 6'o55;
        m_score = 0;
        m_cnt   = 0;
        m_state = M_IDLE;
    endtask

    task automatic model_reset();
        model_restart();
        m_data     = '0;
        m_lfsr     = 6'd1;
        m_prev_any = 1'b0;
    endtask

    task automatic model_step();
        logic [5:0] hn;
        bit eat, hit;
        hn    = neighbour(m_body[0], m_pend);
        m_dir = m_pend;
        eat   = (hn == m_food);
        hit   = 1'b0;
        for (int i = 0; i < m_body.size(); i++) begin
            if (!(i == m_body.size() - 1 && !eat) && m_body[i] == hn) hit = 1'b1;
        end
        if (hit) begin
            m_state = M_OVER;
        end else begin
            m_body.push_front(hn);
            if (!eat || m_body.size() > MAXL) void'(m_body.pop_back());
            if (eat) begin
                if (m_score != 6'd63) m_score = m_score + 6'd1;
                m_state = M_PLACE;
            end
        end
    endtask

    // One rising clock edge of the game as seen from the rules.
    task automatic model_clock(logic fr, logic [3:0] b);
        bit      press;
        mstate_e was;
        int      old_dir, sel;
        press   = (b != 0) && !m_prev_any;
        was     = m_state;
        old_dir = m_dir;
        if (m_state != M_OVER) m_data = picture();
        case (m_state)
            M_IDLE:  if (press) m_state = M_RUN;
            M_RUN: begin
                if (fr) begin
                    if (m_cnt == FPS - 1) begin
                        m_cnt = 0;
                        model_step();
                    end else begin
                        m_cnt++;
                    end
                end
            end
            M_PLACE: begin
                if (!in_body(m_lfsr)) begin
                    m_food  = m_lfsr;
                    m_state = M_RUN;
                end
            end
            default: if (press) model_restart();
        endcase
        if (was != M_OVER && b != 0) begin
            sel = pick(b);
            if (sel != opposite(old_dir)) m_pend = sel;
        end
        m_lfsr     = {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
        m_prev_any = (b != 0);
    endtask

    task automatic chk64(input string nm, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            misc++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    task automatic check_model(input string nm);
        vectors++;
        if (bus.o_Data !== m_data || bus.o_Score !== m_score ||
            bus.o_fGameOver !== (m_state == M_OVER)) begin
            misc++;
            $display("FAIL %s t=%0t: data=%h score=%0d over=%b, expected data=%h score=%0d over=%b",
                     nm, $time, bus.o_Data, bus.o_Score, bus.o_fGameOver,
                     m_data, m_score, (m_state == M_OVER));
        end
    endtask

    // Drive inputs from a falling edge, clock once, check the model just after the rising edge.
    task automatic tick(input logic fr, input logic [3:0] b);
        bus.i_fFrame = fr;
        bus.i_Btn    = b;
        @(posedge clk);
        model_clock(fr, b);
        #1;
        check_model("cycle");
        @(negedge clk);
    endtask

    task automatic frames(input int n, input logic [3:0] b);
        repeat (n) begin
            tick(1'b1, b);
            tick(1'b0, b);
        end
    endtask

    task automatic press_btn(input logic [3:0] b);
        tick(1'b0, b);
        tick(1'b0, 4'h0);
    endtask

    task automatic settle(input int n);
        repeat (n) tick(1'b0, 4'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("async reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  press;
        int          nframes;
        logic [63:0] mask;
        logic [63:0] exp_data;
        int          ones;
        logic [5:0]  score;
        logic        over;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] rbtn;
        int         d;

        vecs[0]  = '{4'h0,   0, ALL, RESET_MAP,              4, 6'd0, 1'b0};
        vecs[1]  = '{4'h0, 200, ALL, RESET_MAP,              4, 6'd0, 1'b0};
        vecs[2]  = '{4'h1,  50, ALL, 64'h0000_2000_1C00_0000, 4, 6'd0, 1'b0};
        vecs[3]  = '{4'h8,  50, ALL, 64'h0000_2000_1810_0000, 4, 6'd0, 1'b0};
        vecs[4]  = '{4'h4,  50, ALL, 64'h0000_2000_1010_1000, 4, 6'd0, 1'b0};
        vecs[5]  = '{4'h0,  50, ALL, 64'h0000_2000_0010_1010, 4, 6'd0, 1'b0};
        vecs[6]  = '{4'h0,  50, ALL, 64'h1000_2000_0000_1010, 4, 6'd0, 1'b0};
        vecs[7]  = '{4'h1,  50, ALL, 64'h3000_2000_0000_0010, 4, 6'd0, 1'b0};
        vecs[8]  = '{4'h0,  50, ALL, 64'h7000_2000_0000_0000, 4, 6'd0, 1'b0};
        vecs[9]  = '{4'h0,  50, ALL, 64'hE000_2000_0000_0000, 4, 6'd0, 1'b0};
        vecs[10] = '{4'h0,  50, ALL, 64'hC100_2000_0000_0000, 4, 6'd0, 1'b0};
        vecs[11] = '{4'h8, 100, ALL, 64'h0101_2100_0000_0000, 4, 6'd0, 1'b0};
        vecs[12] = '{4'h1, 200, ALL, 64'h0000_3C00_0000_0000, 4, 6'd0, 1'b0};
        vecs[13] = '{4'h0,  50, 64'h0000_3C00_0000_0000, 64'h0000_3C00_0000_0000, 5, 6'd1, 1'b0};

        rst_n        = 1'b0;
        bus.i_fFrame = 1'b0;
        bus.i_Btn    = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk64("reset data", bus.o_Data, 64'd0);
        chk64("reset score", 64'(bus.o_Score), 64'd0);
        chk64("reset over", 64'(bus.o_fGameOver), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].press != 4'h0) press_btn(vecs[i].press);
            frames(vecs[i].nframes, 4'h0);
            settle(8);
            chk64($sformatf("vec%0d data", i), bus.o_Data & vecs[i].mask, vecs[i].exp_data);
            chk64($sformatf("vec%0d ones", i), 64'($countones(bus.o_Data)), 64'(vecs[i].ones));
            chk64($sformatf("vec%0d score", i), 64'(bus.o_Score), 64'(vecs[i].score));
            chk64($sformatf("vec%0d over", i), 64'(bus.o_fGameOver), 64'(vecs[i].over));
        end

        // Steer to the next food: run right until its column, then up until eaten.
        for (int k = 0; k < 40 && m_body.size() < 5; k++) begin
            if (m_dir == 1 && m_body[0][2:0] == m_food[2:0]) press_btn(4'b1000);
            frames(FPS, 4'h0);
            settle(8);
        end
        chk64("len5 ones", 64'($countones(bus.o_Data)), 64'd6);

        // Three clockwise turns bring the head back onto the segment behind it.
        d = m_dir;
        repeat (3) begin
            d = clockwise(d);
            press_btn(4'(d));
            frames(FPS, 4'h0);
            settle(8);
        end
        chk64("collide over", 64'(bus.o_fGameOver), 64'd1);
        frames(60, 4'h0);
        chk64("over held", 64'(bus.o_fGameOver), 64'd1);

        press_btn(4'b0010);
        settle(4);
        chk64("restart data", bus.o_Data, RESET_MAP);
        chk64("restart score", 64'(bus.o_Score), 64'd0);
        chk64("restart over", 64'(bus.o_fGameOver), 64'd0);

        rbtn = 4'h0;
        for (int n = 0; n < 20000; n++) begin
            if ($urandom_range(0, 3999) == 0) do_reset();
            if ($urandom_range(0, 15) == 0)
                rbtn = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            tick($urandom_range(0, 3) != 0, rbtn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
